// File: rtl/reg_file.sv
// Two-read, one-write register file with a post-reset clearing sweep; r0 reads as zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LastIdx = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic wr_commit;
  assign wr_commit = wr_en && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          if (wr_commit) begin
            mem_q[wr_addr] <= wr_data;
          end
        end
      endcase
    end
  end

  // Reads return zero in INIT and for r0 regardless of memory contents.
  always_comb begin
    rd_data1 = '0;
    if (state_q == StRun && rd_addr1 != '0) begin
      rd_data1 = mem_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && wr_addr == rd_addr1) begin
        rd_data1 = wr_data;
      end
`endif
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (state_q == StRun && rd_addr2 != '0) begin
      rd_data2 = mem_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && wr_addr == rd_addr2) begin
        rd_data2 = wr_data;
      end
`endif
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: init sweep timing, table of RUN
// read/write vectors, and reset corner sequences.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        ready;

  int checks = 0;
  int errors = 0;

  reg_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;  // expected without forwarding
    logic [31:0] exp2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Counts rising edges until ready is seen; 41 means it never rose.
  task automatic wait_ready(output int n);
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs [13];
  int   n;
  logic [31:0] e1, e2;

  initial begin
    reset    = 1'b1;
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678};
    vecs[6]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd7,  32'h0,        32'h12345678};
    vecs[7]  = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 5'd5,  32'h11111111, 5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd1,  32'h11111111, 32'h0};
    vecs[11] = '{1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  32'h0,        32'h0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  32'hA5A5A5A5, 32'h0};

    // Initial reset and sweep timing
    @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {31'b0, ready}, 32'h0);
    reset = 1'b0;
    wait_ready(n);
    check("init_edges", n, 32'd32);

    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = a[4:0];
      rd_addr2 = 5'(31 - a);
      #1;
      check($sformatf("post_init_rd1_r%0d", a), rd_data1, 32'h0);
      check($sformatf("post_init_rd2_r%0d", 31 - a), rd_data2, 32'h0);
    end

    // RUN vectors: compare same-cycle reads before the committing edge
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wr_en    = vecs[i].we;
      wr_addr  = vecs[i].wa;
      wr_data  = vecs[i].wd;
      rd_addr1 = vecs[i].ra1;
      rd_addr2 = vecs[i].ra2;
      e1 = vecs[i].exp1;
      e2 = vecs[i].exp2;
`ifdef REGFILE_BYPASS_EN
      if (vecs[i].we && vecs[i].wa != 5'd0 && vecs[i].wa == vecs[i].ra1) e1 = vecs[i].wd;
      if (vecs[i].we && vecs[i].wa != 5'd0 && vecs[i].wa == vecs[i].ra2) e2 = vecs[i].wd;
`endif
      #1;
      check($sformatf("vec%0d_rd1", i), rd_data1, e1);
      check($sformatf("vec%0d_rd2", i), rd_data2, e2);
    end

    // Reset during RUN clears everything again
    @(negedge clk);
    wr_en = 1'b0;
    reset_pulse();
    #1;
    rd_addr1 = 5'd9;
    rd_addr2 = 5'd5;
    #1;
    check("ready_after_run_reset", {31'b0, ready}, 32'h0);
    check("init_forces_rd1", rd_data1, 32'h0);
    wait_ready(n);
    check("reinit_edges", n, 32'd32);
    @(negedge clk);
    #1;
    check("r9_cleared", rd_data1, 32'h0);
    check("r5_cleared", rd_data2, 32'h0);

    // Reset at init edge 10, with write attempts to r3 throughout INIT
    reset_pulse();
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hBADC0DE3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    check("restart_edges", n, 32'd32);
    @(negedge clk);
    wr_en    = 1'b0;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd3;
    #1;
    check("r3_after_init_rd1", rd_data1, 32'h0);
    check("r3_after_init_rd2", rd_data2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
